// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch unit: next-PC select encodings, fetch FSM states
// and the default boot address.
package pc_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } fetch_state_e;

    // Branch displacement is a signed word offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc.sv
// Combinational next-PC generator: sequential, branch, jump and register-indirect targets.
module npc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [25:0] imm,
    input  logic [31:0] ra,
    output logic [31:0] pc4,
    output logic [31:0] npc_out,
    output logic        ra_misaligned
);

    assign pc4           = pc + 32'd4;
    assign ra_misaligned = |ra[1:0];

    always_comb begin
        npc_out = pc4;
        case (npc_op_e'(npc_op))
            NPC_PLUS4:  npc_out = pc4;
            NPC_BRANCH: npc_out = pc4 + branch_offset(imm[15:0]);
            NPC_JUMP:   npc_out = {pc4[31:28], imm, 2'b00};
            NPC_JR:     npc_out = {ra[31:2], 2'b00};
            default:    npc_out = pc4;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: holds PC, requests the instruction word, holds it until the
// datapath commits, then advances PC and the retired-instruction counter.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  NPCOp,
    input  logic [25:0] IMM,
    input  logic [31:0] RA,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign,
    output logic [31:0] instret
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  instret_q, instret_d;

    logic [31:0]  pc4_w;
    logic [31:0]  npc_w;
    logic         ra_misaligned_w;
    logic         capture_w;
    logic         retire_w;

    npc u_npc (
        .pc            (pc_q),
        .npc_op        (NPCOp),
        .imm           (IMM),
        .ra            (RA),
        .pc4           (pc4_w),
        .npc_out       (npc_w),
        .ra_misaligned (ra_misaligned_w)
    );

    // Data can land either in the accepting cycle or later while waiting.
    assign capture_w = ((state_q == ST_REQ) && imem_ready && imem_rvalid) ||
                       ((state_q == ST_WAIT) && imem_rvalid);
    assign retire_w  = (state_q == ST_HOLD) && commit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ready) begin
                    state_d = imem_rvalid ? ST_HOLD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (commit) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_REQ);
        instr_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        instret_d  = instret_q;
        if (capture_w) begin
            instr_d = imem_rdata;
        end
        if (retire_w) begin
            pc_d      = npc_w;
            instret_d = instret_q + 32'd1;
            if ((npc_op_e'(NPCOp) == NPC_JR) && ra_misaligned_w) begin
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            misalign_q <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            instret_q  <= instret_d;
        end
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign PC4       = pc4_w;
    assign instr     = instr_q;
    assign misalign  = misalign_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch: reset, zero-latency fetch, branch/jump/JR targets,
// memory stalls, reset during a transaction and 32-bit wraparound.
module tb_pc_fetch;

    logic        clk;
    logic        rstn;
    logic [1:0]  NPCOp;
    logic [25:0] IMM;
    logic [31:0] RA;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] instret;

    int n_cmp;
    int n_fail;

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .NPCOp       (NPCOp),
        .IMM         (IMM),
        .RA          (RA),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .PC4         (PC4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .misalign    (misalign),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_commit(input logic [1:0] op, input logic [25:0] imm, input logic [31:0] ra);
        NPCOp = op; IMM = imm; RA = ra; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] data);
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
        @(negedge clk);
        imem_ready = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (PC !== 32'h3000) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", PC, 32'h3000); end
        n_cmp++; if (PC4 !== 32'h3004) begin n_fail++; $display("[TB] FAIL reset_pc4: got %h expected %h", PC4, 32'h3004); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, 32'h3000); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
        n_cmp++; if ({instr_valid, imem_req, misalign} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {instr_valid, imem_req, misalign}); end
        n_cmp++; if (instret !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instret: got %h expected 0", instret); end
    endtask

    task automatic test_first_fetch;
        rstn = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2002_0001;
        @(negedge clk);
        n_cmp++; if ({imem_req, instr_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL first_req: got %b expected 10", {imem_req, instr_valid}); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("[TB] FAIL first_addr: got %h expected %h", imem_addr, 32'h3000); end
        @(negedge clk);
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        n_cmp++; if ({imem_req, instr_valid} !== 2'b01) begin n_fail++; $display("[TB] FAIL first_valid: got %b expected 01", {imem_req, instr_valid}); end
        n_cmp++; if (instr !== 32'h2002_0001) begin n_fail++; $display("[TB] FAIL first_instr: got %h expected %h", instr, 32'h2002_0001); end
    endtask

    task automatic test_branch;
        do_commit(2'b01, 26'h000FFFF, 32'h0);
        n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("[TB] FAIL branch_back_addr: got %h expected %h", imem_addr, 32'h3000); end
        n_cmp++; if (instret !== 32'd1) begin n_fail++; $display("[TB] FAIL branch_instret: got %h expected 1", instret); end
        n_cmp++; if ({imem_req, instr_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL branch_state: got %b expected 10", {imem_req, instr_valid}); end
        do_fetch(32'h1111_0000);
        n_cmp++; if (instr !== 32'h1111_0000) begin n_fail++; $display("[TB] FAIL branch_instr: got %h expected %h", instr, 32'h1111_0000); end
    endtask

    task automatic test_jump_jr;
        do_commit(2'b00, 26'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h3004) begin n_fail++; $display("[TB] FAIL plus4_addr: got %h expected %h", imem_addr, 32'h3004); end
        do_fetch(32'h0800_0C10);
        do_commit(2'b10, 26'h0000C10, 32'h0);
        n_cmp++; if (imem_addr !== 32'h3040) begin n_fail++; $display("[TB] FAIL jump_addr: got %h expected %h", imem_addr, 32'h3040); end
        n_cmp++; if (instret !== 32'd3) begin n_fail++; $display("[TB] FAIL jump_instret: got %h expected 3", instret); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL jump_misalign: got %b expected 0", misalign); end
        do_fetch(32'h03E0_0008);
        do_commit(2'b11, 26'h0, 32'h0000_3102);
        n_cmp++; if (imem_addr !== 32'h3100) begin n_fail++; $display("[TB] FAIL jr_addr: got %h expected %h", imem_addr, 32'h3100); end
        n_cmp++; if (PC4 !== 32'h3104) begin n_fail++; $display("[TB] FAIL jr_pc4: got %h expected %h", PC4, 32'h3104); end
        n_cmp++; if (misalign !== 1'b1) begin n_fail++; $display("[TB] FAIL jr_misalign: got %b expected 1", misalign); end
        n_cmp++; if (instret !== 32'd4) begin n_fail++; $display("[TB] FAIL jr_instret: got %h expected 4", instret); end
    endtask

    task automatic test_stall;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b0; imem_rvalid = (i == 2); commit = (i % 2 == 0);
            @(negedge clk);
            n_cmp++; if ({imem_req, instr_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL stall_req[%0d]: got %b expected 10", i, {imem_req, instr_valid}); end
            n_cmp++; if (imem_addr !== 32'h3100) begin n_fail++; $display("[TB] FAIL stall_addr[%0d]: got %h expected %h", i, imem_addr, 32'h3100); end
            n_cmp++; if (instret !== 32'd4) begin n_fail++; $display("[TB] FAIL stall_instret[%0d]: got %h expected 4", i, instret); end
        end
        commit = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        n_cmp++; if ({imem_req, instr_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL wait_enter: got %b expected 00", {imem_req, instr_valid}); end
        for (int i = 0; i < 2; i++) begin
            commit = 1'b1;
            @(negedge clk);
            n_cmp++; if ({imem_req, instr_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL wait_state[%0d]: got %b expected 00", i, {imem_req, instr_valid}); end
            n_cmp++; if (instret !== 32'd4) begin n_fail++; $display("[TB] FAIL wait_instret[%0d]: got %h expected 4", i, instret); end
        end
        commit = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0003;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL late_valid: got %b expected 1", instr_valid); end
        n_cmp++; if (instr !== 32'hCAFE_0003) begin n_fail++; $display("[TB] FAIL late_instr: got %h expected %h", instr, 32'hCAFE_0003); end
        n_cmp++; if (PC !== 32'h3100) begin n_fail++; $display("[TB] FAIL late_pc: got %h expected %h", PC, 32'h3100); end
        n_cmp++; if (misalign !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_sticky: got %b expected 1", misalign); end
    endtask

    task automatic test_reset_in_wait;
        do_commit(2'b00, 26'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h3104) begin n_fail++; $display("[TB] FAIL pre_wait_addr: got %h expected %h", imem_addr, 32'h3104); end
        imem_ready = 1'b1; imem_rvalid = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (PC !== 32'h3000) begin n_fail++; $display("[TB] FAIL async_pc: got %h expected %h", PC, 32'h3000); end
        n_cmp++; if (instret !== 32'd0) begin n_fail++; $display("[TB] FAIL async_instret: got %h expected 0", instret); end
        n_cmp++; if ({misalign, imem_req, instr_valid} !== 3'b000) begin n_fail++; $display("[TB] FAIL async_flags: got %b expected 000", {misalign, imem_req, instr_valid}); end
        @(negedge clk);
        rstn = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        n_cmp++; if ({imem_req, instr_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL restart_req: got %b expected 10", {imem_req, instr_valid}); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("[TB] FAIL restart_addr: got %h expected %h", imem_addr, 32'h3000); end
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stale_valid: got %b expected 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("[TB] FAIL stale_instr: got %h expected 0", instr); end
        do_fetch(32'h0000_0123);
        n_cmp++; if (instr !== 32'h0000_0123) begin n_fail++; $display("[TB] FAIL refetch_instr: got %h expected %h", instr, 32'h0000_0123); end
    endtask

    task automatic test_wrap;
        do_commit(2'b11, 26'h0, 32'hFFFF_FFFC);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL top_addr: got %h expected %h", imem_addr, 32'hFFFF_FFFC); end
        n_cmp++; if (PC4 !== 32'h0) begin n_fail++; $display("[TB] FAIL top_pc4: got %h expected 0", PC4); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL aligned_jr: got %b expected 0", misalign); end
        do_fetch(32'h0000_0000);
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        do_commit(2'b00, 26'h0, 32'h0);
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_addr: got %h expected 0", imem_addr); end
        n_cmp++; if (instret !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_instret: got %h expected 0", instret); end
        do_fetch(32'h1000_0010);
        do_commit(2'b01, 26'h3FF0010, 32'h0);
        n_cmp++; if (imem_addr !== 32'h0000_0044) begin n_fail++; $display("[TB] FAIL fwd_branch: got %h expected %h", imem_addr, 32'h44); end
        n_cmp++; if (instret !== 32'd1) begin n_fail++; $display("[TB] FAIL fwd_instret: got %h expected 1", instret); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rstn = 1'b0; NPCOp = 2'b00; IMM = 26'h0; RA = 32'h0; commit = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_first_fetch();
        test_branch();
        test_jump_jr();
        test_stall();
        test_reset_in_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
